// File: rtl/vm_pkg.sv
// Shared types and constants for the Vedic multiply-accumulate datapath.
// Holds the accumulator FSM state encoding, operand/product widths and
// the helper that sizes the beat counter from the vector length.
package vm_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;

    // Counter width for a 0..len-1 counter; a one-product vector still
    // needs a one-bit register so the counter never collapses to zero width.
    function automatic int cnt_width(input int len);
        return (len <= 1) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/vm_dot_acc_if.sv
// Operand input stream and result output stream of the dot-product
// accumulator. master = producer/consumer side, slave = accumulator side.
interface vm_dot_acc_if
    import vm_pkg::*;
#(
    parameter int ACC_W = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] in_a;
    logic [OPND_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/vm_prod_stage.sv
// Product register stage: multiplies the accepted operand pair with the
// Vedic multiplier and registers the product together with a one-cycle
// valid so the accumulator adds it on the following edge.
module vm_prod_stage
    import vm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p_q,
    output logic              p_vld
);

    logic [PROD_W-1:0] prod;

    vm_vedic4x4 u_mul (
        .a (a),
        .b (b),
        .p (prod)
    );

    // Capture the product only on an accepted beat; valid pulses for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            p_vld <= 1'b0;
        end else begin
            p_vld <= beat;
            if (beat) begin
                p_q <= prod;
            end
        end
    end

endmodule

// File: rtl/vm_vedic4x4.sv
// Combinational 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
// Built from four 2x2 vertical-and-crosswise partial products that are
// shifted into place and summed.
module vm_vedic4x4
    import vm_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    // 2x2 Vedic cell: AND terms plus two half adders.
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, c1, t3;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        c1 = t1 & t2;
        t3 = x[1] & y[1];
        return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
    endfunction

    logic [3:0] pp_ll;
    logic [3:0] pp_hl;
    logic [3:0] pp_lh;
    logic [3:0] pp_hh;

    // Form the four crosswise partial products and align them into the product.
    always_comb begin
        pp_ll = vedic2x2(a[1:0], b[1:0]);
        pp_hl = vedic2x2(a[3:2], b[1:0]);
        pp_lh = vedic2x2(a[1:0], b[3:2]);
        pp_hh = vedic2x2(a[3:2], b[3:2]);
        p = {4'b0000, pp_ll}
          + {2'b00, pp_hl, 2'b00}
          + {2'b00, pp_lh, 2'b00}
          + {pp_hh, 4'b0000};
    end

endmodule

// File: rtl/vm_dot_acc.sv
// Streaming dot-product accumulator (multiply-accumulate over LEN beats).
// Accepts one 4-bit operand pair per beat, sums LEN products and holds the
// result on the output stream until it is taken.
// Optional build macro VM_DOT_SAT_EN: when defined the accumulator
// saturates at all-ones instead of wrapping; out_ovf flags either event.
module vm_dot_acc
    import vm_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    vm_dot_acc_if.slave  bus
);

    localparam int                CNT_W    = cnt_width(LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nx;
    logic [ACC_W:0]     sum_w;
    logic               carry;
    logic               ovf;
    logic               beat;
    logic               done;
    logic [PROD_W-1:0]  p_q;
    logic               p_vld;

    // Ready and valid decode from registered state only.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;

    assign beat = bus.in_valid && bus.in_ready;
    assign done = (state == HOLD) && bus.out_ready;

    vm_prod_stage u_prod (
        .clk   (clk),
        .rst   (rst),
        .beat  (beat),
        .a     (bus.in_a),
        .b     (bus.in_b),
        .p_q   (p_q),
        .p_vld (p_vld)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: the last beat drains one cycle, then the result is held until taken.
    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (beat && (cnt == CNT_LAST)) state_nx = DRAIN;
            DRAIN:   state_nx = HOLD;
            HOLD:    if (bus.out_ready) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    // Beat counter wraps on the last beat of a vector and clears when the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (done) begin
            cnt <= '0;
        end else if (beat) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Widened add exposes the carry out of the accumulator's top bit.
    always_comb begin
        sum_w = {1'b0, acc} + (ACC_W + 1)'(p_q);
        carry = sum_w[ACC_W];
`ifdef VM_DOT_SAT_EN
        acc_nx = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
        acc_nx = sum_w[ACC_W-1:0];
`endif
    end

    // Accumulator and sticky overflow flag, cleared when the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (done) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (p_vld) begin
            acc <= acc_nx;
            ovf <= ovf | carry;
        end
    end

endmodule

// File: tb/tb_vm_dot_acc.sv
// Directed testbench for vm_dot_acc. Three instances share one stimulus
// stream: LEN=4/ACC_W=16, LEN=4/ACC_W=8 (overflow behaviour, with or
// without VM_DOT_SAT_EN) and LEN=1/ACC_W=16.
module tb_vm_dot_acc;
    import vm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_ready;

    int n_cmp = 0;
    int n_err = 0;

`ifdef VM_DOT_SAT_EN
    localparam int EXP8 = 255;
`else
    localparam int EXP8 = 132;
`endif

    logic [3:0] gap_a   [4] = '{4'd3, 4'd0, 4'd7, 4'd1};
    logic [3:0] gap_b   [4] = '{4'd5, 4'd9, 4'd7, 4'd1};
    int         gap_pre [4] = '{0, 15, 15, 64};

    logic [3:0] one_a   [3] = '{4'd13, 4'd9, 4'd6};
    logic [3:0] one_b   [3] = '{4'd11, 4'd14, 4'd10};
    int         one_exp [3] = '{143, 126, 60};

    always #5 clk = ~clk;

    vm_dot_acc_if #(.ACC_W(16)) bus16 ();
    vm_dot_acc_if #(.ACC_W(8))  bus8 ();
    vm_dot_acc_if #(.ACC_W(16)) bus1 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.in_a      = in_a;
    assign bus16.in_b      = in_b;
    assign bus16.out_ready = out_ready;
    assign bus8.in_valid   = in_valid;
    assign bus8.in_a       = in_a;
    assign bus8.in_b       = in_b;
    assign bus8.out_ready  = out_ready;
    assign bus1.in_valid   = in_valid;
    assign bus1.in_a       = in_a;
    assign bus1.in_b       = in_b;
    assign bus1.out_ready  = out_ready;

    vm_dot_acc #(.LEN(4), .ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    vm_dot_acc #(.LEN(4), .ACC_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    vm_dot_acc #(.LEN(1), .ACC_W(16)) dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // One cycle of stimulus, presented at the falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                                 input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = rdy;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready",  32'(bus16.in_ready),  1);
        checkOutput("reset_out_valid", 32'(bus16.out_valid), 0);
        checkOutput("reset_out_sum",   32'(bus16.out_sum),   0);
        checkOutput("reset_out_ovf",   32'(bus16.out_ovf),   0);
        rst = 1'b0;

        // Four (15,15) beats back-to-back, result taken immediately.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd15, 4'd15, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("max_drain_out_valid", 32'(bus16.out_valid), 0);
        checkOutput("max_drain_in_ready",  32'(bus16.in_ready),  0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("max_hold_out_valid", 32'(bus16.out_valid), 1);
        checkOutput("max_sum16",          32'(bus16.out_sum),   900);
        checkOutput("max_ovf16",          32'(bus16.out_ovf),   0);
        checkOutput("max_sum8",           32'(bus8.out_sum),    EXP8);
        checkOutput("max_ovf8",           32'(bus8.out_ovf),    1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("max_clr_out_valid", 32'(bus16.out_valid), 0);
        checkOutput("max_clr_in_ready",  32'(bus16.in_ready),  1);
        checkOutput("max_clr_sum16",     32'(bus16.out_sum),   0);
        checkOutput("max_clr_ovf8",      32'(bus8.out_ovf),    0);

        // Beats separated by three idle cycles, then backpressure in HOLD.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, gap_a[i], gap_b[i], 1'b0);
            checkOutput("gap_acc_hold",  32'(bus16.out_sum),  gap_pre[i]);
            checkOutput("gap_in_ready",  32'(bus16.in_ready), 1);
            if (i < 3) repeat (3) applyStimulus(1'b0, 4'd15, 4'd15, 1'b0);
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
        checkOutput("gap_drain_out_valid", 32'(bus16.out_valid), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4'd15, 4'd15, 1'b0);
            checkOutput("bp_out_valid", 32'(bus16.out_valid), 1);
            checkOutput("bp_in_ready",  32'(bus16.in_ready),  0);
            checkOutput("bp_out_sum",   32'(bus16.out_sum),   65);
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("bp_last_out_sum",  32'(bus16.out_sum), 65);
        checkOutput("bp_last_sum8",     32'(bus8.out_sum),  65);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("bp_clr_out_valid", 32'(bus16.out_valid), 0);
        checkOutput("bp_clr_in_ready",  32'(bus16.in_ready),  1);
        checkOutput("bp_clr_out_sum",   32'(bus16.out_sum),   0);

        // Reset in the middle of a vector discards the partial sum.
        applyStimulus(1'b1, 4'd15, 4'd15, 1'b1);
        applyStimulus(1'b1, 4'd15, 4'd15, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_sum",  32'(bus16.out_sum),  0);
        checkOutput("rst_mid_ovf8",     32'(bus8.out_ovf),   0);
        checkOutput("rst_mid_in_ready", 32'(bus16.in_ready), 1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd1, 4'd1, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("rst_vec_out_valid", 32'(bus16.out_valid), 1);
        checkOutput("rst_vec_sum16",     32'(bus16.out_sum),   4);
        checkOutput("rst_vec_ovf16",     32'(bus16.out_ovf),   0);
        checkOutput("rst_vec_sum8",      32'(bus8.out_sum),    4);
        checkOutput("rst_vec_ovf8",      32'(bus8.out_ovf),    0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);

        // Back-to-back vectors with the next pair offered while not ready.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'd2, 4'd2, 1'b1);
        applyStimulus(1'b1, 4'd1, 4'd3, 1'b1);
        checkOutput("b2b_drain_in_ready",  32'(bus16.in_ready),  0);
        checkOutput("b2b_drain_out_valid", 32'(bus16.out_valid), 0);
        applyStimulus(1'b1, 4'd1, 4'd3, 1'b1);
        checkOutput("b2b_first_out_valid", 32'(bus16.out_valid), 1);
        checkOutput("b2b_first_sum",       32'(bus16.out_sum),   16);
        checkOutput("b2b_first_in_ready",  32'(bus16.in_ready),  0);
        applyStimulus(1'b1, 4'd1, 4'd3, 1'b1);
        checkOutput("b2b_second_start_in_ready", 32'(bus16.in_ready), 1);
        checkOutput("b2b_second_start_sum",      32'(bus16.out_sum),  0);
        repeat (3) applyStimulus(1'b1, 4'd1, 4'd3, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("b2b_second_drain_out_valid", 32'(bus16.out_valid), 0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("b2b_second_out_valid", 32'(bus16.out_valid), 1);
        checkOutput("b2b_second_sum",       32'(bus16.out_sum),   12);

        // LEN=1: every beat passes through DRAIN and HOLD on its own.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, one_a[i], one_b[i], 1'b1);
            checkOutput("len1_in_ready", 32'(bus1.in_ready), 1);
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
            checkOutput("len1_drain_in_ready",  32'(bus1.in_ready),  0);
            checkOutput("len1_drain_out_valid", 32'(bus1.out_valid), 0);
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
            checkOutput("len1_out_valid", 32'(bus1.out_valid), 1);
            checkOutput("len1_out_sum",   32'(bus1.out_sum),   one_exp[i]);
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("len1_clr_in_ready", 32'(bus1.in_ready), 1);
        checkOutput("len1_clr_out_sum",  32'(bus1.out_sum),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vm_dot_acc.md
# vm_dot_acc

Sequential dot-product accumulator that sits directly downstream of the team's combinational 4x4 Vedic multiplier. It accepts one 4-bit operand pair per handshake and registers the 8-bit product. It accumulates LEN consecutive products and presents the sum on a valid/ready output port. This is the first clocked stage of the multiplier datapath and turns the bare multiplier into a streaming MAC unit.

## Interface
- LEN, 4: products per dot product; legal range 1..256.
- ACC_W, 16: accumulator/output width; must be ≥ 8.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  4  unsigned multiplicand.
- in_b  input  4  unsigned multiplier.
- out_valid  output  1  dot-product result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum.
- out_ovf  output  1  sum exceeded 2^ACC_W−1 during this vector.

## Operation
- Beat: in_valid && in_ready at a rising edge.
- Product stage: on a beat, p_q ← in_a*in_b (8-bit, via the Vedic multiplier) and p_vld ← 1. Otherwise p_vld ← 0.
- Accumulate: when p_vld=1, acc ← acc + zero-extend(p_q).
  - The carry out of bit ACC_W−1 sets the sticky ovf bit.
- Beat counter cnt counts 0..LEN−1. It increments on each beat and wraps to 0 on the LEN-th beat.
- FSM states:
  - ACCUM: in_ready=1. The LEN-th beat moves the FSM to DRAIN.
  - DRAIN: in_ready=0. Lasts one cycle while the last product enters acc, then moves to HOLD.
  - HOLD: in_ready=0, out_valid=1. When out_ready=1, acc, ovf and cnt clear and the FSM returns to ACCUM.
- LEN=1: every beat goes ACCUM → DRAIN → HOLD.
- in_valid gaps in ACCUM are legal. acc and cnt hold while no beat occurs.
- in_a/in_b are ignored when no beat occurs.
- out_sum = acc and out_ovf = ovf. Both are stable for the whole of HOLD.
- Arithmetic: all operands are unsigned. Worst-case sum is 225*LEN; ACC_W ≥ 8+ceil(log2 LEN) avoids overflow.
- Reset (at any time, including mid-vector or in HOLD): the partial vector is discarded.

## Timing
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, p_vld=0, cnt=0.
- Latency:
  - The product is registered at the beat edge E0 and accumulated at E1.
  - For the last beat at E0, out_valid is high from E1 (DRAIN→HOLD transition at E1).
- in_ready is a registered-state decode. It has no combinational path from in_valid or out_ready.
- out_valid is held until out_ready. The output handshake edge clears acc, and in_ready is high in the following cycle.
- A beat cannot coincide with HOLD, because in_ready=0.
- Peak throughput: LEN beats per LEN+2 cycles, assuming out_ready is tied high.

## Configuration
- VM_DOT_SAT_EN defined:
  - acc saturates at 2^ACC_W−1 when an addition would overflow.
  - out_ovf still reports that saturation occurred.
- VM_DOT_SAT_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - out_ovf is the sticky carry-out flag.

## Structure
- Shared package vm_pkg:
  - state enum {ACCUM, DRAIN, HOLD}.
  - constant PROD_W=8 and constant OPND_W=4.
  - function for the counter width, clog2(LEN).
- One sub-module, vm_prod_stage:
  - instantiates the 4x4 Vedic multiplier;
  - registers p_q/p_vld with asynchronous active-high rst;
  - outputs the registered product and its valid.
- Top level holds the FSM, beat counter, accumulator and saturation logic.

## Test plan
- LEN=4, ACC_W=16: four beats of (15,15) back-to-back, out_ready=1 → out_sum=900 (0x384), out_ovf=0, out_valid high exactly 2 cycles after the 4th beat.
- LEN=4: beats (3,5),(0,9),(7,7),(1,1) with in_valid idle 3 cycles between beats → out_sum=65; acc unchanged during gaps.
- Backpressure: out_ready low for 5 cycles in HOLD → in_ready=0, out_sum/out_valid stable; the ready edge clears the result, and in_ready=1 next cycle.
- Reset mid-vector: assert rst after 2 beats of (15,15), then four beats of (1,1) → out_sum=4, out_ovf=0.
- ACC_W=8, LEN=4: four beats of (15,15):
  - without VM_DOT_SAT_EN → out_sum=900 mod 256=132, out_ovf=1;
  - with VM_DOT_SAT_EN → out_sum=255, out_ovf=1.
- Back-to-back vectors: a (2,2)x4 vector with out_ready tied 1, followed immediately by a (1,3)x4 vector → results 16 then 12; the second vector's acc starts from 0.
